// File: rtl/tl_sram_arbiter.sv
// Two-master TileLink UL/UH arbiter in front of one SRAM slave port.
// Round-robin, message-granular A arbitration; D routed back by the top source bit.
module tl_sram_arbiter #(
    parameter int TL_RS = 4,
    parameter int TL_AW = 16
) (
    input  logic             arb_clock_i,
    input  logic             arb_reset_i,

    input  logic [2:0]       m0_a_opcode,
    input  logic [2:0]       m0_a_param,
    input  logic [3:0]       m0_a_size,
    input  logic [TL_RS-1:0] m0_a_source,
    input  logic [TL_AW-1:0] m0_a_address,
    input  logic [3:0]       m0_a_mask,
    input  logic [31:0]      m0_a_data,
    input  logic             m0_a_corrupt,
    input  logic             m0_a_valid,
    output logic             m0_a_ready,
    output logic [2:0]       m0_d_opcode,
    output logic [1:0]       m0_d_param,
    output logic [3:0]       m0_d_size,
    output logic [TL_RS-1:0] m0_d_source,
    output logic             m0_d_denied,
    output logic [31:0]      m0_d_data,
    output logic             m0_d_corrupt,
    output logic             m0_d_valid,
    input  logic             m0_d_ready,

    input  logic [2:0]       m1_a_opcode,
    input  logic [2:0]       m1_a_param,
    input  logic [3:0]       m1_a_size,
    input  logic [TL_RS-1:0] m1_a_source,
    input  logic [TL_AW-1:0] m1_a_address,
    input  logic [3:0]       m1_a_mask,
    input  logic [31:0]      m1_a_data,
    input  logic             m1_a_corrupt,
    input  logic             m1_a_valid,
    output logic             m1_a_ready,
    output logic [2:0]       m1_d_opcode,
    output logic [1:0]       m1_d_param,
    output logic [3:0]       m1_d_size,
    output logic [TL_RS-1:0] m1_d_source,
    output logic             m1_d_denied,
    output logic [31:0]      m1_d_data,
    output logic             m1_d_corrupt,
    output logic             m1_d_valid,
    input  logic             m1_d_ready,

    output logic [2:0]       s_a_opcode,
    output logic [2:0]       s_a_param,
    output logic [3:0]       s_a_size,
    output logic [TL_RS:0]   s_a_source,
    output logic [TL_AW-1:0] s_a_address,
    output logic [3:0]       s_a_mask,
    output logic [31:0]      s_a_data,
    output logic             s_a_corrupt,
    output logic             s_a_valid,
    input  logic             s_a_ready,
    input  logic [2:0]       s_d_opcode,
    input  logic [1:0]       s_d_param,
    input  logic [3:0]       s_d_size,
    input  logic [TL_RS:0]   s_d_source,
    input  logic             s_d_denied,
    input  logic [31:0]      s_d_data,
    input  logic             s_d_corrupt,
    input  logic             s_d_valid,
    output logic             s_d_ready
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t      state;
    logic        prio;
    logic [10:0] beats;
    logic        grant;
    logic        a_fire;
    logic [10:0] msg_beats;
    logic        sel;

    // Data-carrying opcodes (Put*/Arithmetic/Logical) span 2^(size-2) beats on the 32-bit bus.
    function automatic logic [10:0] beat_count(input logic [2:0] opcode, input logic [3:0] size);
        if (opcode < 3'd4 && size >= 4'd3 && size <= 4'd12)
            return 11'd1 << (size - 4'd2);
        return 11'd1;
    endfunction

    always_comb begin
        grant = 1'b0;
        case (state)
            OWN0:    grant = 1'b0;
            OWN1:    grant = 1'b1;
            default: grant = (m0_a_valid && m1_a_valid) ? prio : m1_a_valid;
        endcase
    end

    assign s_a_opcode  = grant ? m1_a_opcode  : m0_a_opcode;
    assign s_a_param   = grant ? m1_a_param   : m0_a_param;
    assign s_a_size    = grant ? m1_a_size    : m0_a_size;
    assign s_a_source  = {grant, grant ? m1_a_source : m0_a_source};
    assign s_a_address = grant ? m1_a_address : m0_a_address;
    assign s_a_mask    = grant ? m1_a_mask    : m0_a_mask;
    assign s_a_data    = grant ? m1_a_data    : m0_a_data;
    assign s_a_corrupt = grant ? m1_a_corrupt : m0_a_corrupt;
    assign s_a_valid   = !arb_reset_i && (grant ? m1_a_valid : m0_a_valid);
    assign m0_a_ready  = !arb_reset_i && s_a_ready && !grant;
    assign m1_a_ready  = !arb_reset_i && s_a_ready && grant;

    assign a_fire    = s_a_valid && s_a_ready;
    assign msg_beats = beat_count(s_a_opcode, s_a_size);

    // A message that is presented but not yet accepted still locks the grant,
    // so the slave never sees its fields change under a stalled valid.
    always_ff @(posedge arb_clock_i) begin
        if (arb_reset_i) begin
            state <= IDLE;
            prio  <= 1'b0;
            beats <= 11'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_a_valid) begin
                        if (!s_a_ready) begin
                            state <= grant ? OWN1 : OWN0;
                            beats <= msg_beats;
                        end else if (msg_beats == 11'd1) begin
                            prio <= !grant;
                        end else begin
                            state <= grant ? OWN1 : OWN0;
                            beats <= msg_beats - 11'd1;
                        end
                    end
                end
                OWN0, OWN1: begin
                    if (a_fire) begin
                        if (beats == 11'd1) begin
                            state <= IDLE;
                            prio  <= !grant;
                            beats <= 11'd0;
                        end else begin
                            beats <= beats - 11'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sel = s_d_source[TL_RS];

    assign m0_d_valid   = !arb_reset_i && s_d_valid && !sel;
    assign m1_d_valid   = !arb_reset_i && s_d_valid && sel;
    assign s_d_ready    = !arb_reset_i && (sel ? m1_d_ready : m0_d_ready);

    assign m0_d_opcode  = s_d_opcode;
    assign m0_d_param   = s_d_param;
    assign m0_d_size    = s_d_size;
    assign m0_d_source  = s_d_source[TL_RS-1:0];
    assign m0_d_denied  = s_d_denied;
    assign m0_d_data    = s_d_data;
    assign m0_d_corrupt = s_d_corrupt;
    assign m1_d_opcode  = s_d_opcode;
    assign m1_d_param   = s_d_param;
    assign m1_d_size    = s_d_size;
    assign m1_d_source  = s_d_source[TL_RS-1:0];
    assign m1_d_denied  = s_d_denied;
    assign m1_d_data    = s_d_data;
    assign m1_d_corrupt = s_d_corrupt;

endmodule
